// File: rtl/tt_um_sid.sv
// Three-voice SID-style synthesizer: register file, phase/waveform/ADSR voices,
// state-variable filter, volume mix and an 8-bit PWM audio output.

module sid_voice (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [7:0]  wr_data,
  output logic [11:0] vout
);
  typedef enum logic [1:0] {IDLE, ATTACK, DECAY_SUSTAIN, RELEASE} env_state_t;

  logic [15:0] freq, acc, acc_n;
  logic [11:0] pw, wave, saw_w, tri_w, pul_w, noi_w, scaled;
  logic [7:0]  ad, sr, ctrl, env, env_n;
  logic [22:0] lfsr;
  logic [17:0] rate_cnt, rate_cnt_n, period;
  logic [3:0]  rate;
  logic        gate_q, step;
  env_state_t  state, state_n;
  logic        unused;

  assign unused = &{1'b0, ctrl[3:1]};

  always_ff @(posedge clk)
    if (rst) begin
      freq <= '0; pw <= '0; ad <= '0; sr <= '0; ctrl <= '0;
    end else if (wr_en) begin
      case (wr_addr)
        3'd0: freq[7:0]  <= wr_data;
        3'd1: freq[15:8] <= wr_data;
        3'd2: pw[7:0]    <= wr_data;
        3'd3: pw[11:8]   <= wr_data[3:0];
        3'd4: ad         <= wr_data;
        3'd5: sr         <= wr_data;
        3'd6: ctrl       <= wr_data;
        default: ;
      endcase
    end

  assign acc_n = acc + freq;
  assign saw_w = acc[15:4];
  assign tri_w = acc[14:3] ^ {12{acc[15]}};
  assign pul_w = (acc[15:4] >= pw) ? 12'hFFF : 12'h000;
  assign noi_w = lfsr[22:11];

  always_comb begin
    wave = 12'hFFF;
    if (ctrl[4]) wave = wave & tri_w;
    if (ctrl[5]) wave = wave & saw_w;
    if (ctrl[6]) wave = wave & pul_w;
    if (ctrl[7]) wave = wave & noi_w;
    if (ctrl[7:4] == 4'd0) wave = '0;
  end

  // Offset-binary to two's complement: flipping the MSB subtracts 0x800.
  assign scaled = 12'((20'(wave) * 20'(env)) >> 8);
  assign vout   = {~scaled[11], scaled[10:0]};

  always_comb begin
    rate = 4'd0;
    case (state)
      ATTACK:        rate = ad[7:4];
      DECAY_SUSTAIN: rate = ad[3:0];
      RELEASE:       rate = sr[3:0];
      default:       rate = 4'd0;
    endcase
  end

  assign period = 18'd6 << rate;
  assign step   = (rate_cnt == period - 18'd1);

  always_comb begin
    state_n    = state;
    env_n      = env;
    rate_cnt_n = step ? '0 : rate_cnt + 18'd1;
    if (ctrl[0] && !gate_q) begin
      state_n = ATTACK; rate_cnt_n = '0;
    end else if (!ctrl[0] && gate_q) begin
      state_n = RELEASE; rate_cnt_n = '0;
    end else begin
      case (state)
        ATTACK:
          if (env == 8'hFF) begin
            state_n = DECAY_SUSTAIN; rate_cnt_n = '0;
          end else if (step) env_n = env + 8'd1;
        DECAY_SUSTAIN:
          if (step && env > {sr[7:4], sr[7:4]}) env_n = env - 8'd1;
        RELEASE:
          if (env == 8'h00) begin
            state_n = IDLE; rate_cnt_n = '0;
          end else if (step) env_n = env - 8'd1;
        default: rate_cnt_n = '0;
      endcase
    end
  end

  always_ff @(posedge clk)
    if (rst) begin
      acc <= '0; lfsr <= 23'h7FFFF8; env <= '0; state <= IDLE;
      rate_cnt <= '0; gate_q <= 1'b0;
    end else if (tick) begin
      acc <= acc_n;
      if (!acc[11] && acc_n[11]) lfsr <= {lfsr[21:0], lfsr[22] ^ lfsr[17]};
      env      <= env_n;
      state    <= state_n;
      rate_cnt <= rate_cnt_n;
      gate_q   <= ctrl[0];
    end
endmodule

module tt_um_sid (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  localparam int NUM_VOICES = 3;
  localparam int TICK_DIV   = 30;

  // rst_n is an active-high reset despite its name.
  logic        we_q, wr_pend, we_rise, tick;
  logic [1:0]  wr_tgt;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data, res_route, mode_vol, out_sample, sample_n, pwm_cnt, pwm_smp;
  logic [10:0] fc;
  logic [4:0]  div;
  logic [NUM_VOICES-1:0][11:0] vout;
  logic signed [17:0] lp, bp, hp, bp_n, lp_n;
  logic signed [31:0] f_in, dry, damp, fcoef, vol_s, hp_w, f_out, mix, smp;
  logic        unused;

  assign unused  = &{1'b0, ena, ui_in[6:5], fc[4:0], res_route[3], mode_vol[7]};
  assign we_rise = ui_in[7] & ~we_q;
  assign tick    = (div == 5'(TICK_DIV - 1));

  always_ff @(posedge clk)
    if (rst_n) begin
      we_q <= 1'b0; wr_pend <= 1'b0; wr_tgt <= '0; wr_addr <= '0; wr_data <= '0;
    end else begin
      we_q    <= ui_in[7];
      wr_pend <= we_rise;
      if (we_rise) begin
        wr_tgt <= ui_in[4:3]; wr_addr <= ui_in[2:0]; wr_data <= uio_in;
      end
    end

  always_ff @(posedge clk)
    if (rst_n) begin
      fc <= '0; res_route <= '0; mode_vol <= '0;
    end else if (wr_pend && wr_tgt == 2'd3) begin
      case (wr_addr)
        3'd0: fc[2:0]   <= wr_data[2:0];
        3'd1: fc[10:3]  <= wr_data;
        3'd2: res_route <= wr_data;
        3'd3: mode_vol  <= wr_data;
        default: ;
      endcase
    end

  always_ff @(posedge clk)
    if (rst_n) div <= '0;
    else       div <= tick ? '0 : div + 5'd1;

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    sid_voice u_voice (
      .clk    (clk),
      .rst    (rst_n),
      .tick   (tick),
      .wr_en  (wr_pend && (wr_tgt == 2'(i))),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .vout   (vout[i])
    );
  end

  function automatic logic signed [17:0] sat18(input logic signed [31:0] x);
    if (x > 32'sd131071)       return 18'sh1FFFF;
    else if (x < -32'sd131072) return 18'sh20000;
    else                       return 18'(x);
  endfunction

  always_comb begin
    f_in = '0;
    dry  = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      if (res_route[i]) f_in = f_in + 32'($signed(vout[i]));
      else              dry  = dry  + 32'($signed(vout[i]));
    damp  = 32'sd16 - $signed({28'd0, res_route[7:4]});
    fcoef = $signed({26'd0, fc[10:5]});
    vol_s = $signed({28'd0, mode_vol[3:0]});
    hp_w  = f_in - 32'(lp) - ((32'(bp) * damp) >>> 3);
    hp    = sat18(hp_w);
    bp_n  = sat18(32'(bp) + ((fcoef * 32'(hp)) >>> 9));
    lp_n  = sat18(32'(lp) + ((fcoef * 32'(bp_n)) >>> 9));
    if (mode_vol[6:4] == 3'b000) f_out = f_in;
    else begin
      f_out = '0;
      if (mode_vol[4]) f_out = f_out + 32'(lp_n);
      if (mode_vol[5]) f_out = f_out + 32'(bp_n);
      if (mode_vol[6]) f_out = f_out + 32'(hp);
    end
    mix = f_out + dry;
    // vol/16 gain plus >>4 to bring the 12-bit voice range to 8 bits
    smp = ((mix * vol_s) >>> 8) + 32'sd128;
    if (smp < 0)               sample_n = 8'h00;
    else if (smp > 32'sd255)   sample_n = 8'hFF;
    else                       sample_n = 8'(smp);
  end

  always_ff @(posedge clk)
    if (rst_n) begin
      lp <= '0; bp <= '0; out_sample <= '0;
    end else if (tick) begin
      lp <= lp_n; bp <= bp_n; out_sample <= sample_n;
    end

  always_ff @(posedge clk)
    if (rst_n) begin
      pwm_cnt <= '0; pwm_smp <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (pwm_cnt == 8'hFF) pwm_smp <= out_sample;
    end

  assign uo_out  = {7'd0, pwm_cnt < pwm_smp};
  assign uio_out = '0;
  assign uio_oe  = '0;
endmodule

// File: tb/tb_tt_um_sid.sv
// Bench for tt_um_sid: a per-tick arithmetic model predicts each PWM sample and
// every 256-cycle PWM window's high count is compared against it.

module tb_tt_um_sid;
  logic clk = 1'b0;
  logic rst_n, ena;
  logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
  int checks = 0, failures = 0;

  typedef enum {E_IDLE, E_ATTACK, E_DECAY, E_RELEASE} env_phase_e;
  int m_freq[3], m_pw[3], m_ad[3], m_sr[3], m_ctrl[3];
  int m_acc[3], m_lfsr[3], m_env[3], m_cnt[3], m_gate[3];
  env_phase_e m_ph[3];
  int m_fc, m_rr, m_mv, m_sample, pwm_exp, hi_cnt, cyc;
  longint m_lp, m_bp;

  always #21 clk = ~clk;

  tt_um_sid dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_freq[i] = 0; m_pw[i] = 0; m_ad[i] = 0; m_sr[i] = 0; m_ctrl[i] = 0;
      m_acc[i] = 0; m_lfsr[i] = 'h7FFFF8; m_env[i] = 0; m_cnt[i] = 0;
      m_gate[i] = 0; m_ph[i] = E_IDLE;
    end
    m_fc = 0; m_rr = 0; m_mv = 0; m_lp = 0; m_bp = 0;
    m_sample = 0; pwm_exp = 0; hi_cnt = 0; cyc = 0;
  endfunction

  function automatic void model_write(int tgt, int addr, int d);
    if (tgt < 3) begin
      case (addr)
        0: m_freq[tgt] = (m_freq[tgt] & 'hFF00) | d;
        1: m_freq[tgt] = (m_freq[tgt] & 'h00FF) | (d << 8);
        2: m_pw[tgt]   = (m_pw[tgt] & 'hF00) | d;
        3: m_pw[tgt]   = (m_pw[tgt] & 'h0FF) | ((d & 15) << 8);
        4: m_ad[tgt]   = d;
        5: m_sr[tgt]   = d;
        6: m_ctrl[tgt] = d;
        default: ;
      endcase
    end else begin
      case (addr)
        0: m_fc = (m_fc & 'h7F8) | (d & 7);
        1: m_fc = (m_fc & 'h007) | (d << 3);
        2: m_rr = d;
        3: m_mv = d;
        default: ;
      endcase
    end
  endfunction

  function automatic int vwave(int i);
    int a, sel, w;
    a = m_acc[i];
    sel = (m_ctrl[i] >> 4) & 15;
    if (sel == 0) return 0;
    w = 'hFFF;
    if (sel & 1) w &= ((a >> 3) & 'hFFF) ^ ((a >= 'h8000) ? 'hFFF : 0);
    if (sel & 2) w &= a >> 4;
    if (sel & 4) w &= ((a >> 4) >= m_pw[i]) ? 'hFFF : 0;
    if (sel & 8) w &= (m_lfsr[i] >> 11) & 'hFFF;
    return w;
  endfunction

  function automatic longint sat18(longint x);
    if (x > 131071) return 131071;
    if (x < -131072) return -131072;
    return x;
  endfunction

  function automatic void model_tick();
    longint v, fin, dry, hp, bpn, lpn, fo, mix, s;
    int f, a_new, per, rate, gate;
    bit stp;
    fin = 0; dry = 0;
    for (int i = 0; i < 3; i++) begin
      v = (longint'(vwave(i)) * m_env[i]) / 256 - 2048;
      if ((m_rr >> i) & 1) fin += v; else dry += v;
    end
    f   = (m_fc >> 5) & 63;
    hp  = sat18(fin - m_lp - ((m_bp * (16 - (m_rr >> 4))) >>> 3));
    bpn = sat18(m_bp + ((f * hp) >>> 9));
    lpn = sat18(m_lp + ((f * bpn) >>> 9));
    if ((m_mv & 'h70) == 0) fo = fin;
    else begin
      fo = 0;
      if (m_mv & 'h10) fo += lpn;
      if (m_mv & 'h20) fo += bpn;
      if (m_mv & 'h40) fo += hp;
    end
    mix = fo + dry;
    s = ((mix * (m_mv & 15)) >>> 8) + 128;
    m_sample = (s < 0) ? 0 : (s > 255) ? 255 : int'(s);
    m_lp = lpn; m_bp = bpn;
    for (int i = 0; i < 3; i++) begin
      a_new = (m_acc[i] + m_freq[i]) % 65536;
      if (((m_acc[i] & 'h800) == 0) && ((a_new & 'h800) != 0))
        m_lfsr[i] = ((m_lfsr[i] << 1) | (((m_lfsr[i] >> 22) ^ (m_lfsr[i] >> 17)) & 1)) & 'h7FFFFF;
      m_acc[i] = a_new;
      // envelope: one step every 6*2^rate ticks of the active phase
      gate = m_ctrl[i] & 1;
      rate = (m_ph[i] == E_ATTACK) ? (m_ad[i] >> 4) :
             (m_ph[i] == E_DECAY)  ? (m_ad[i] & 15) : (m_sr[i] & 15);
      per = 6 << rate;
      stp = (m_cnt[i] == per - 1);
      m_cnt[i] = stp ? 0 : m_cnt[i] + 1;
      if (gate && !m_gate[i]) begin m_ph[i] = E_ATTACK; m_cnt[i] = 0; end
      else if (!gate && m_gate[i]) begin m_ph[i] = E_RELEASE; m_cnt[i] = 0; end
      else case (m_ph[i])
        E_ATTACK:  if (m_env[i] == 255) begin m_ph[i] = E_DECAY; m_cnt[i] = 0; end
                   else if (stp) m_env[i]++;
        E_DECAY:   if (stp && m_env[i] > (m_sr[i] >> 4) * 17) m_env[i]--;
        E_RELEASE: if (m_env[i] == 0) begin m_ph[i] = E_IDLE; m_cnt[i] = 0; end
                   else if (stp) m_env[i]--;
        default: ;
      endcase
      m_gate[i] = gate;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst_n) model_reset();
    else begin
      cyc++;
      if (cyc % 256 == 0) begin pwm_exp = m_sample; hi_cnt = 0; end
      if (cyc % 30 == 0) model_tick();
    end
    @(negedge clk);
    if (rst_n) begin
      chk("reset_uo_out", 32'(uo_out), 0);
    end else begin
      hi_cnt += int'(uo_out[0]);
      if (cyc % 256 == 255) begin
        chk("pwm_duty", 32'(hi_cnt), 32'(pwm_exp));
        chk("uio_zero", 32'({uio_out, uio_oe, uo_out[7:1]}), 0);
      end
    end
  endtask

  // Writes start just after a tick so they commit well before the next one.
  task automatic wr(int tgt, int addr, int data, int hold = 1, bit change = 1'b0);
    while (cyc % 30 != 1) step();
    ui_in  = {3'b000, 2'(tgt), 3'(addr)};
    uio_in = 8'(data);
    step();
    ui_in[7] = 1'b1;
    for (int k = 0; k < hold; k++) begin
      step();
      if (change && k == 2) uio_in = ~8'(data);
    end
    ui_in[7] = 1'b0;
    step();
    model_write(tgt, addr, data);
  endtask

  initial begin
    ena = 1'b1; ui_in = '0; uio_in = '0; rst_n = 1'b1;
    model_reset();
    repeat (5) step();
    rst_n = 1'b0;
    repeat (3 * 256) step();

    // voice0 saw 0x0024 with A/D 0x00, S/R 0xE0; voices 1-2 routed into a
    // closed (fc=0) lowpass so voice0 dominates; run through attack and decay
    wr(0, 0, 'h24); wr(0, 4, 'h00); wr(0, 5, 'hE0);
    wr(1, 0, 'h55); wr(1, 1, 'h02); wr(1, 4, 'h00); wr(1, 5, 'hF0);
    wr(2, 1, 'h05); wr(2, 4, 'h00); wr(2, 5, 'hF0);
    wr(3, 2, 'h06); wr(3, 3, 'h1F);
    wr(0, 6, 'h21); wr(1, 6, 'h41); wr(2, 6, 'h11);
    repeat (200 * 256) step();

    for (int r = 0; r < 6; r++) begin
      for (int v = 0; v < 3; v++) begin
        wr(v, 0, $urandom_range(255));
        wr(v, 1, $urandom_range(63));
        wr(v, 2, $urandom_range(255));
        wr(v, 3, $urandom_range(15));
        wr(v, 6, ($urandom_range(1, 15) << 4) | 1);
      end
      wr(3, 0, $urandom_range(7));
      wr(3, 1, $urandom_range(255));
      wr(3, 2, $urandom_range(255));
      wr(3, 3, $urandom_range(127) | 8);
      repeat (4 * 256) step();
    end

    // saw-only bypass so a frequency change is visible
    wr(0, 6, 'h21); wr(3, 2, 'h00); wr(3, 3, 'h0F);
    wr(0, 1, 'h03);
    wr(0, 0, 'hA5, 10, 1'b1);
    wr(3, 5, $urandom_range(255));
    repeat (3 * 256) step();

    for (int v = 0; v < 3; v++) wr(v, 6, 'h20);
    repeat (8 * 256) step();

    rst_n = 1'b1;
    repeat (5) step();
    rst_n = 1'b0;
    repeat (3 * 256) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
